// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch unit, the fetch queue and decode.
// The master side is the environment: it drives enqueue data, deq_ready and flush.
// The slave side is the queue itself.
interface fetch_queue_if #(
  parameter int FETCH_WIDTH     = 2,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int DEPTH           = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Redirect: drop everything held in the queue
  logic                            flush;

  // Enqueue side (from fetch)
  logic                            enq_valid;
  logic [FETCH_WIDTH-1:0][31:0]    enq_inst;
  logic [INST_ADDR_WIDTH-1:0]      enq_pc;
  logic                            enq_ready;
  logic                            fetch_stall;

  // Dequeue side (to decode)
  logic                            deq_valid;
  logic [FETCH_WIDTH-1:0][31:0]    deq_inst;
  logic [INST_ADDR_WIDTH-1:0]      deq_pc;
  logic                            deq_ready;

  // Status
  logic [CNT_W-1:0]                occupancy;

  modport master (
    output flush, enq_valid, enq_inst, enq_pc, deq_ready,
    input  enq_ready, fetch_stall, deq_valid, deq_inst, deq_pc, occupancy
  );

  modport slave (
    input  flush, enq_valid, enq_inst, enq_pc, deq_ready,
    output enq_ready, fetch_stall, deq_valid, deq_inst, deq_pc, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer of {instruction bundle, bundle PC} entries that
// decouples the fetch unit from decode. Strict FIFO, back-pressure when full,
// synchronous flush on redirect. DEPTH must be a power of two and >= 2 so the
// pointers can wrap by plain overflow.
module fetch_queue #(
  parameter int FETCH_WIDTH     = 2,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int DEPTH           = 4
) (
  input  logic       clk,
  input  logic       reset,
  fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [FETCH_WIDTH-1:0][31:0] bundle_t;

  logic [PTR_W-1:0]           rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]           wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]           count_reg, count_next;

  bundle_t                    inst_mem [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic                       enq_ready;
  logic                       deq_valid;
  logic                       enq_fire;
  logic                       deq_fire;

  // Status derived purely from registered count; no enqueue-through when full
  always_comb begin
    enq_ready = (count_reg != CNT_W'(DEPTH));
    deq_valid = (count_reg != '0);
    enq_fire  = bus.enq_valid & enq_ready;
    deq_fire  = deq_valid & bus.deq_ready;
  end

  // Drive the interface outputs; head entry is read combinationally
  always_comb begin
    bus.enq_ready   = enq_ready;
    bus.fetch_stall = ~enq_ready;
    bus.deq_valid   = deq_valid;
    bus.deq_inst    = inst_mem[rd_ptr_reg];
    bus.deq_pc      = pc_mem[rd_ptr_reg];
    bus.occupancy   = count_reg;
  end

  // Pointer and count update; flush overrides both handshakes
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (bus.flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (enq_fire) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (enq_fire && !deq_fire) begin
        count_next = count_reg + CNT_W'(1);
      end else if (deq_fire && !enq_fire) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  // Control state; reset empties the queue immediately, without a clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage: each slot captures the bundle when it is the write target.
  // Data is never reset; it is only observed while deq_valid is high.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Write one entry on an accepted, non-flushed enqueue
      always_ff @(posedge clk) begin
        if (enq_fire && !bus.flush && (wr_ptr_reg == PTR_W'(gi))) begin
          inst_mem[gi] <= bus.enq_inst;
          pc_mem[gi]   <= bus.enq_pc;
        end
      end
    end
  endgenerate

  // Occupancy stays within 0..DEPTH and the pointers never move on an empty queue
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_reg <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(deq_fire && (count_reg == '0)));
endmodule
